data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder on the MEM stage of the 5-stage MIPS pipeline. It is the memory end of the datapath's memRead/memWrite/address/write-data interface.
- It accepts one load or store at a time and holds the pipeline with a stall signal while it serves the request.
- It completes the request after a fixed latency and returns read data with a one-cycle done pulse.
- It replaces the single-cycle data memory when modelling slow memory.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; power of two.
- LATENCY, 3: busy cycles per access; legal range 1..15.
- AW, 8: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request, from the MEM-stage M bit 0.
- mem_write  in  1  store request, from the MEM-stage M bit 1.
- addr  in  32  byte address, from the MEM-stage ALU result.
- wdata  in  32  store data.
- rdata  out  32  load data; valid only while done=1.
- done  out  1  one-cycle completion pulse.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- err  out  1  one-cycle pulse, coincident with done, flagging a faulted request.

Behaviour:
- Reset is asynchronous, active-high and fixed as such. On reset:
  - state=IDLE, counter=0, rdata=0, done=0, err=0.
  - All DEPTH words are cleared to 0.
  - Any in-flight request is abandoned with no write performed.
- req = mem_read | mem_write.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If req=1, capture addr, wdata and op, load counter=LATENCY-1, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter≠0, decrement it.
  - If counter=0, go to DONE and perform the access at that edge:
    - Store: mem[addr[AW+1:2]] <= wdata.
    - Load: rdata <= mem[addr[AW+1:2]].
- DONE:
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
  - A request present in the DONE cycle is the completed one and is not re-accepted.
- mem_stall is combinational: (state==IDLE & req) | state==BUSY. It is 0 in DONE so the pipeline advances.
- Timing: a request first seen in IDLE at cycle T gives:
  - stall high for cycles T..T+LATENCY;
  - done at cycle T+LATENCY+1;
  - back-to-back accesses every LATENCY+2 cycles.
- The requester holds addr, wdata and op stable while stall is high. The block uses only its captured copies.
- Fault cases (err=1 with done; no array write; rdata=0):
  - mem_read & mem_write both 1 at capture.
  - addr[1:0]≠0 (misaligned).
  - addr[31:AW+2]≠0 (out of range).
- rdata keeps its last value after done and is don't-care to consumers.
- Reset asserted mid-BUSY: the write is suppressed, state is IDLE immediately, and stall drops asynchronously. A request still present after reset release is accepted as new.
- Writes are word-only; no byte enables.

Decomposition:
- Shared package, in the pipeline's defines file:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - localparam CNT_W=4.
- Natural sub-module: mem_latency_counter. It is a loadable down-counter with a zero flag that holds at 0.
- The top level holds the FSM, capture registers, array and fault checks.

Test Plan:
- Reset then a load at addr=0x10 with LATENCY=3 → stall high for 4 cycles, done on the 5th, rdata=0x00000000, err=0.
- Store wdata=0xDEADBEEF at 0x20, then a load at 0x20 → the second request is accepted in the cycle after done; rdata=0xDEADBEEF.
- Store at 0x21 (misaligned) → err=1 with done; a subsequent load at 0x20 returns the prior value 0xDEADBEEF.
- Store at 0x400 with DEPTH=256 (out of range) → err=1; mem[0] is unchanged when read back.
- Assert rst during the 2nd BUSY cycle of a store of 0x12345678 to 0x30 → stall drops without waiting for a clock; no done; a load of 0x30 afterwards returns 0.
- mem_read=mem_write=1 at 0x08 → full-latency stall, then err=1 and done=1; array unchanged.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder on the MEM stage.
package data_mem_responder_pkg;

  // Width of the latency down-counter (covers LATENCY up to 15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // A request is faulted if it is both a load and a store, is not word aligned,
  // or addresses beyond the array (any byte-address bit above the word index set).
  function automatic logic req_fault(input logic        rd,
                                     input logic        wr,
                                     input logic [31:0] a,
                                     input int unsigned aw);
    logic both;
    logic misaligned;
    logic out_of_range;
    both         = rd & wr;
    misaligned   = (a[1:0] != 2'b00);
    out_of_range = ((a >> (aw + 2)) != 32'd0);
    return both | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/data_mem_responder_counter.sv
// Loadable down-counter with a zero flag; holds at zero once it gets there.
module mem_latency_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Load takes priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one load/store at a time,
// stalls the pipeline for a fixed latency, then pulses done (and err on a fault).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        mem_stall,
  output logic        err
);

  logic [31:0]   mem [DEPTH];
  state_e        state;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          fault_q;

  logic req;
  logic cnt_load;
  logic cnt_zero;
  logic access;

  assign req      = mem_read | mem_write;
  assign cnt_load = (state == StIdle) && req;
  // The access happens on the edge that leaves BUSY.
  assign access   = (state == StBusy) && cnt_zero;

  // Gated by rst so the stall drops the moment reset is asserted, even if the
  // requester is still presenting its request.
  assign mem_stall = ~rst & (((state == StIdle) & req) | (state == StBusy));

  mem_latency_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (state == StBusy),
    .zero     (cnt_zero)
  );

  // Control FSM with request capture and registered done/err/rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req) begin
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            fault_q <= req_fault(mem_read, mem_write, addr, AW);
            state   <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_zero) begin
            state <= StDone;
            done  <= 1'b1;
            if (fault_q) begin
              err   <= 1'b1;
              rdata <= '0;
            end else if (rd_q) begin
              rdata <= mem[idx_q];
            end
          end
        end
        // The request still visible here is the one just completed; never re-accept it.
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Storage array: cleared on reset, written only by a non-faulted store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (access && wr_q && !fault_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table of load/store vectors with
// a queue of expected completions, plus a mid-access reset sequence.
module tb_data_mem_responder;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        mem_stall;
  logic        err;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  data_mem_responder #(
    .DEPTH   (256),
    .LATENCY (LAT),
    .AW      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .mem_stall (mem_stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input logic exp_er, input logic chk_rd);
    exp_t e;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    e.rdata     = exp_rd;
    e.err       = exp_er;
    e.chk_rdata = chk_rd;
    sb.push_back(e);
  endtask

  // Counts stalled cycles until done, compares against the queued expectation,
  // then drops the request and confirms done/err were single-cycle pulses.
  task automatic finish_req(input string nm);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 0;
    #1;
    for (int c = 0; c < 64; c++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (mem_stall === 1'b1) n++;
      @(negedge clk);
      #1;
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, " stall_cycles"}, n, LAT + 1);
      chk({nm, " stall_in_done"}, 32'(mem_stall), 32'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({nm, " err"}, 32'(err), 32'(e.err));
        if (e.chk_rdata) chk({nm, " rdata"}, rdata, e.rdata);
      end else begin
        chk({nm, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, " done_pulse"}, 32'(done), 32'd0);
    chk({nm, " err_pulse"}, 32'(err), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;

    //          rd    wr    addr          wdata         exp_rdata     err   chk
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0021, 32'h1111_1111, 32'h0,       1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, 32'h0,       1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,       1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0,       1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,        32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,        32'h0000_0000, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        32'h0000_0000, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};

    // Reset state, including a request presented while reset is held.
    repeat (3) @(negedge clk);
    #1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset stall", 32'(mem_stall), 32'd0);
    mem_read = 1'b1;
    #1;
    chk("reset stall_with_req", 32'(mem_stall), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 14; i++) begin
      start_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].chk_rdata);
      finish_req($sformatf("vec%0d", i));
    end

    // Reset during the second BUSY cycle of a store: no write, no done, stall drops at once.
    mem_write = 1'b1;
    mem_read  = 1'b0;
    addr      = 32'h0000_0030;
    wdata     = 32'h1234_5678;
    #1;
    chk("abort stall_idle", 32'(mem_stall), 32'd1);
    @(negedge clk);
    #1;
    chk("abort stall_busy1", 32'(mem_stall), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort stall_async", 32'(mem_stall), 32'd0);
    chk("abort done_async", 32'(done), 32'd0);
    // Switch to a load of the same word, held across reset release: accepted as new.
    mem_write = 1'b0;
    mem_read  = 1'b1;
    start_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("abort done_in_reset", 32'(done), 32'd0);
      chk("abort stall_in_reset", 32'(mem_stall), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    finish_req("post_reset_load30");

    // Reset cleared the array: previously stored words read back as zero.
    start_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b1);
    finish_req("post_reset_load20");
    start_req(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'h0, 1'b0, 1'b1);
    finish_req("post_reset_load3fc");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
